// File: rtl/alu_operand_sequencer.sv
// Sequential front end for the N-bit ALU: loads A, B and opcode under a "next"
// button, runs the ALU for one cycle, then holds its result and flags for display.
module alu_operand_sequencer #(
  parameter int N                  = 4,
  parameter int OP_W               = 3,
  parameter logic [OP_W-1:0] OP_ADD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      data_in,
  input  logic [OP_W-1:0]   op_in,
  input  logic              btn_next,
  input  logic              btn_clr,
  input  logic [N-1:0]      alu_out,
  input  logic [2*N-1:0]    alu_mult,
  input  logic              alu_z,
  input  logic              alu_nf,
  input  logic              alu_v,
  input  logic              alu_cout,
  output logic [N-1:0]      A,
  output logic [N-1:0]      B,
  output logic [OP_W-1:0]   op,
  output logic              cin,
  output logic [N-1:0]      res_q,
  output logic [2*N-1:0]    mult_q,
  output logic [3:0]        flags_q,
  output logic              res_valid,
  output logic [2:0]        state_q
);

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t state, state_d;
  logic   btn_d;
  logic   next_ev;
  logic   ld_a, ld_b, ld_op, latch, drop_valid;

  assign next_ev = btn_next & ~btn_d;
  assign cin     = 1'b0;
  assign state_q = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD_A;
    else        state <= state_d;
  end

  always_comb begin
    state_d    = state;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    ld_op      = 1'b0;
    latch      = 1'b0;
    drop_valid = 1'b0;
    if (btn_clr) begin
      state_d = LOAD_A;
    end else begin
      case (state)
        LOAD_A:  if (next_ev) begin ld_a  = 1'b1; state_d = LOAD_B;  end
        LOAD_B:  if (next_ev) begin ld_b  = 1'b1; state_d = LOAD_OP; end
        LOAD_OP: if (next_ev) begin ld_op = 1'b1; state_d = EXEC;    end
        EXEC:    begin latch = 1'b1; state_d = SHOW; end
        SHOW:    if (next_ev) begin drop_valid = 1'b1; state_d = LOAD_A; end
        default: state_d = LOAD_A;
      endcase
    end
  end

  // btn_d resets high so a button held across reset release gives no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_d     <= 1'b1;
      A         <= '0;
      B         <= '0;
      op        <= OP_ADD;
      res_q     <= '0;
      mult_q    <= '0;
      flags_q   <= '0;
      res_valid <= 1'b0;
    end else begin
      btn_d <= btn_next;
      if (btn_clr) begin
        A         <= '0;
        B         <= '0;
        op        <= OP_ADD;
        res_q     <= '0;
        mult_q    <= '0;
        flags_q   <= '0;
        res_valid <= 1'b0;
      end else begin
        if (ld_a)  A  <= data_in;
        if (ld_b)  B  <= data_in;
        if (ld_op) op <= op_in;
        if (latch) begin
          res_q     <= alu_out;
          mult_q    <= alu_mult;
          flags_q   <= {alu_z, alu_nf, alu_v, alu_cout};
          res_valid <= 1'b1;
        end
        if (drop_valid) res_valid <= 1'b0;
      end
    end
  end

endmodule
